// File: rtl/ifetch.sv
// Instruction fetch: holds PC, requests one word at a time, holds it until commit, then computes the next PC.
// Optional IFETCH_MISALIGN_TRAP_EN: a misaligned next PC traps into a sticky error state instead of being truncated.
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [1:0]  NPCOp,
  input  logic [31:0] RA,
  input  logic        commit,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        addr_err
);

`ifdef IFETCH_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, REQ, VALID, ERR} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_plus4;
  logic [31:0] br_off;
  logic [31:0] npc_raw;
  logic [31:0] npc;
  logic        npc_misaligned;
  logic        pc_load;
  logic        instr_load;

  always_comb begin
    pc_plus4 = PC + 32'd4;
    br_off   = {{14{instr[15]}}, instr[15:0], 2'b00};
    case (NPCOp)
      2'b00:   npc_raw = pc_plus4;
      2'b01:   npc_raw = pc_plus4 + br_off;
      2'b10:   npc_raw = {pc_plus4[31:28], instr[25:0], 2'b00};
      default: npc_raw = RA;
    endcase
    // Without the trap the low bits are simply dropped, so ERR can never be entered.
    npc            = TRAP_EN ? npc_raw : {npc_raw[31:2], 2'b00};
    npc_misaligned = TRAP_EN && (npc_raw[1:0] != 2'b00);
  end

  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    addr_err    = 1'b0;
    pc_load     = 1'b0;
    instr_load  = 1'b0;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_load = 1'b1;
          state_nxt  = VALID;
        end
      end
      VALID: begin
        instr_valid = 1'b1;
        if (commit) begin
          if (npc_misaligned) begin
            state_nxt = ERR;
          end else begin
            pc_load   = 1'b1;
            state_nxt = REQ;
          end
        end
      end
      ERR:     addr_err = TRAP_EN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      PC    <= RESET_PC;
      instr <= '0;
    end else begin
      state <= state_nxt;
      if (pc_load)    PC    <= npc;
      if (instr_load) instr <= imem_rdata;
    end
  end

  assign imem_addr = PC;
  assign PCPlus4   = pc_plus4;

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: fetched words go through a scoreboard queue, next-PC values come from a reference model.
module tb_ifetch;

  logic        clk;
  logic        rstn;
  logic [1:0]  NPCOp;
  logic [31:0] RA;
  logic        commit;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        addr_err;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_instr;

  ifetch #(.RESET_PC(32'h0000_3000)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .NPCOp      (NPCOp),
    .RA         (RA),
    .commit     (commit),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_valid(instr_valid),
    .PC         (PC),
    .PCPlus4    (PCPlus4),
    .addr_err   (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_npc(input logic [1:0] op, input logic [31:0] ra);
    logic [31:0]        p4;
    logic signed [31:0] off;
    p4  = m_pc + 32'd4;
    off = $signed(m_instr[15:0]);
    case (op)
      2'd0:    return p4;
      2'd1:    return p4 + (off * 4);
      2'd2:    return {p4[31:28], m_instr[25:0], 2'b00};
      default: return ra;
    endcase
  endfunction

  // Called at a negedge with the DUT in (or about to enter) REQ.
  task automatic fetch(input logic [31:0] word, input int unsigned delay, input bit prompt);
    int unsigned waited = 0;
    while (imem_req !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("req_seen", {31'd0, imem_req}, 32'd1);
    if (prompt) chk("req_latency", waited, 32'd0);
    chk("imem_addr", imem_addr, m_pc);
    chk("valid_in_req", {31'd0, instr_valid}, 32'd0);
    for (int unsigned i = 0; i < delay; i++) begin
      @(negedge clk);
      chk("req_held", {31'd0, imem_req}, 32'd1);
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    exp_q.push_back(word);
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    chk("valid_after_ack", {31'd0, instr_valid}, 32'd1);
    chk("req_after_ack", {31'd0, imem_req}, 32'd0);
    if (exp_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
    else chk("instr", instr, exp_q.pop_front());
    m_instr = word;
  endtask

  task automatic do_commit(input logic [1:0] op, input logic [31:0] ra);
    logic [31:0] raw;
    bit          trap;
    raw = model_npc(op, ra);
`ifdef IFETCH_MISALIGN_TRAP_EN
    trap = (raw[1:0] != 2'b00);
`else
    trap = 1'b0;
    raw[1:0] = 2'b00;
`endif
    NPCOp  = op;
    RA     = ra;
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    NPCOp  = 2'($urandom_range(3));
    RA     = $urandom;
    if (!trap) m_pc = raw;
    chk("pc_commit", PC, m_pc);
    chk("pcplus4_commit", PCPlus4, m_pc + 32'd4);
    chk("valid_drop", {31'd0, instr_valid}, 32'd0);
    chk("req_commit", {31'd0, imem_req}, trap ? 32'd0 : 32'd1);
    chk("addr_err_commit", {31'd0, addr_err}, trap ? 32'd1 : 32'd0);
  endtask

  initial begin
    rstn = 1'b0; NPCOp = 2'b00; RA = '0; commit = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0;
    m_pc = 32'h0000_3000; m_instr = '0;
    repeat (2) @(negedge clk);
    chk("rst_pc", PC, 32'h0000_3000);
    chk("rst_pcplus4", PCPlus4, 32'h0000_3004);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr_err", {31'd0, addr_err}, 32'd0);

    rstn = 1'b1;
    @(negedge clk);
    fetch(32'hAAAA_0001, 1, 1'b1);
    chk("first_addr", PC, 32'h0000_3000);

    // Held word must survive stray acks and the lack of a commit.
    for (int i = 0; i < 3; i++) begin
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("hold_instr", instr, m_instr);
      chk("hold_valid", {31'd0, instr_valid}, 32'd1);
      chk("hold_req", {31'd0, imem_req}, 32'd0);
    end
    imem_ack = 1'b0;

    do_commit(2'b00, 32'h0);
    chk("seq_pc", PC, 32'h0000_3004);

    // Commit in REQ is ignored.
    commit = 1'b1; NPCOp = 2'b11; RA = 32'h0000_0100;
    @(negedge clk);
    commit = 1'b0;
    chk("commit_in_req_pc", PC, 32'h0000_3004);
    chk("commit_in_req_req", {31'd0, imem_req}, 32'd1);

    fetch(32'h0000_0000, 0, 1'b1);
    do_commit(2'b00, 32'h0);
    fetch(32'h1000_FFFF, 2, 1'b1);
    do_commit(2'b01, 32'h0);
    chk("beq_pc", PC, 32'h0000_3008);
    fetch(32'h0800_0C10, 0, 1'b1);
    do_commit(2'b10, 32'h0);
    chk("j_pc", PC, 32'h0000_3040);

    fetch(32'h0000_0008, 0, 1'b1);
    do_commit(2'b11, 32'hFFFF_FFFC);
    fetch(32'h1234_5678, 1, 1'b1);
    do_commit(2'b00, 32'h0);
    chk("wrap_pc", PC, 32'h0000_0000);
    chk("wrap_pcplus4", PCPlus4, 32'h0000_0004);

    fetch(32'h0000_0008, 0, 1'b1);
    do_commit(2'b11, 32'h0000_3102);
`ifdef IFETCH_MISALIGN_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      imem_ack = 1'b1; commit = 1'b1; NPCOp = 2'b00;
      @(negedge clk);
      chk("err_pc", PC, 32'h0000_0000);
      chk("err_req", {31'd0, imem_req}, 32'd0);
      chk("err_valid", {31'd0, instr_valid}, 32'd0);
      chk("err_flag", {31'd0, addr_err}, 32'd1);
    end
    imem_ack = 1'b0; commit = 1'b0;
`else
    chk("jr_trunc_pc", PC, 32'h0000_3100);
    fetch(32'hCAFE_0001, 0, 1'b1);
`endif

    // Reset mid-VALID (or mid-ERR), then reset mid-REQ with an ack arriving under reset.
    rstn = 1'b0;
    #1;
    chk("rst2_pc", PC, 32'h0000_3000);
    chk("rst2_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst2_instr", instr, 32'h0);
    chk("rst2_addr_err", {31'd0, addr_err}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    m_pc = 32'h0000_3000; m_instr = '0;
    exp_q.delete();
    @(negedge clk);
    chk("rst2_req", {31'd0, imem_req}, 32'd1);

    rstn = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    #1;
    chk("rst3_req", {31'd0, imem_req}, 32'd0);
    chk("rst3_pc", PC, 32'h0000_3000);
    @(negedge clk);
    @(negedge clk);
    chk("rst3_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst3_instr", instr, 32'h0);
    imem_ack = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
    chk("rst3_no_late_valid", {31'd0, instr_valid}, 32'd0);
    fetch(32'h5555_AAAA, 1, 1'b0);
    do_commit(2'b00, 32'h0);
    chk("final_pc", PC, 32'h0000_3004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
